instr_mem_loader: RTL and testbench

- Writer side of the instruction memory: takes a byte stream (valid/ready) carrying a length header and program image, assembles little-endian 32-bit words, and issues single-cycle writes into the instruction memory write port.
- Holds the core in reset while loading.
- Sits between the host/UART byte receiver and the instruction memory in the single-cycle top level.

---
 rtl/rv_loader_pkg.sv | 20 ++
 rtl/instr_mem_loader_byte_word_packer.sv | 46 ++++
 rtl/instr_mem_loader.sv | 133 +++++++++++++
 tb/tb_instr_mem_loader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
`default_nettype none

package rv_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } loader_state_t;

  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;

endpackage

`default_nettype wire

// File: rtl/instr_mem_loader_byte_word_packer.sv
// Collects stream bytes into a little-endian 32-bit word.
`default_nettype none

module byte_word_packer
  import rv_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          push,
  input  logic [7:0]                    byte_in,
  output logic [8*BYTES_PER_WORD-1:0]   word,
  output logic                          word_full
);

  logic [1:0]                  idx_q, idx_d;
  logic [8*BYTES_PER_WORD-1:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear) begin
      idx_d  = '0;
      word_d = '0;
    end else if (push) begin
      word_d[8*idx_q +: 8] = byte_in;
      idx_d                = idx_q + 2'd1;  // wraps to lane 0 after the top lane
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word      = word_q;
  assign word_full = push && !clear && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: length-prefixed byte stream to 32-bit word writes,
// holding the core in reset until the image is in place.
`default_nettype none

module instr_mem_loader
  import rv_loader_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Start,
  input  logic [7:0]  i_Byte,
  input  logic        i_Valid,
  output logic        o_Ready,
  output logic        o_WrEn,
  output logic [31:0] o_WrAddr,
  output logic [31:0] o_WrData,
  output logic        o_CpuHold,
  output logic        o_Done,
  output logic        o_Error,
  output logic [15:0] o_WordCnt
);

  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

  loader_state_t    state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             error_q, error_d;

  logic             xfer;
  logic             pack_clear, pack_push, word_full;
  logic [LEN_W-1:0] len_full, cnt_inc;

  assign xfer = i_Valid && o_Ready;

  byte_word_packer u_packer (
    .clk       (i_Clk),
    .rst       (i_Rst),
    .clear     (pack_clear),
    .push      (pack_push),
    .byte_in   (i_Byte),
    .word      (o_WrData),
    .word_full (word_full)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    error_d    = error_q;
    o_Ready    = 1'b0;
    pack_clear = 1'b0;
    pack_push  = 1'b0;
    len_full   = {i_Byte, len_q[7:0]};
    cnt_inc    = cnt_q + 16'd1;

    case (state_q)
      IDLE, DONE: begin
        if (i_Start) begin
          state_d    = LEN0;
          error_d    = 1'b0;
          cnt_d      = '0;
          addr_d     = BASE_ADDR;
          pack_clear = 1'b1;
        end
      end
      LEN0: begin
        o_Ready = 1'b1;
        if (xfer) begin
          len_d[7:0] = i_Byte;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        o_Ready = 1'b1;
        if (xfer) begin
          len_d = len_full;
          if (len_full == '0) begin
            state_d = DONE;
          end else if (len_full > DEPTH_LEN) begin
            state_d = DONE;
            error_d = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        o_Ready   = 1'b1;
        pack_push = xfer;
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        cnt_d   = cnt_inc;
        addr_d  = addr_q + 32'd4;
        state_d = (cnt_inc == len_q) ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= BASE_ADDR;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      error_q <= error_d;
    end
  end

  assign o_WrEn    = (state_q == WRITE);
  assign o_WrAddr  = addr_q;
  assign o_CpuHold = (state_q == LEN0) || (state_q == LEN1) ||
                     (state_q == DATA) || (state_q == WRITE);
  assign o_Done    = (state_q == DONE);
  assign o_Error   = error_q;
  assign o_WordCnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader (base 0 and base 0x100 instances).
`default_nettype none

module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_Start = 1'b0;
  logic [7:0]  i_Byte = 8'h00;
  logic        i_Valid = 1'b0;

  logic        rdy0, wen0, hold0, done0, err0;
  logic [31:0] addr0, data0;
  logic [15:0] cnt0;
  logic        rdy1, wen1, hold1, done1, err1;
  logic [31:0] addr1, data1;
  logic [15:0] cnt1;

  int checks = 0;
  int errors = 0;

  logic [7:0]  seq [0:15];
  int          wr_n0 = 0;
  int          wr_n1 = 0;
  logic [31:0] wr_addr0 [0:63];
  logic [31:0] wr_data0 [0:63];
  logic [31:0] wr_addr1 [0:63];

  always #5 clk = ~clk;

  instr_mem_loader #(.DEPTH(64), .BASE_ADDR(32'h0000_0000)) dut0 (
    .i_Clk(clk), .i_Rst(rst), .i_Start(i_Start), .i_Byte(i_Byte), .i_Valid(i_Valid),
    .o_Ready(rdy0), .o_WrEn(wen0), .o_WrAddr(addr0), .o_WrData(data0),
    .o_CpuHold(hold0), .o_Done(done0), .o_Error(err0), .o_WordCnt(cnt0)
  );

  instr_mem_loader #(.DEPTH(64), .BASE_ADDR(32'h0000_0100)) dut1 (
    .i_Clk(clk), .i_Rst(rst), .i_Start(i_Start), .i_Byte(i_Byte), .i_Valid(i_Valid),
    .o_Ready(rdy1), .o_WrEn(wen1), .o_WrAddr(addr1), .o_WrData(data1),
    .o_CpuHold(hold1), .o_Done(done1), .o_Error(err1), .o_WordCnt(cnt1)
  );

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wen0 && wr_n0 < 64) begin
      wr_addr0[wr_n0] = addr0;
      wr_data0[wr_n0] = data0;
      wr_n0 = wr_n0 + 1;
    end
    if (wen1 && wr_n1 < 64) begin
      wr_addr1[wr_n1] = addr1;
      wr_n1 = wr_n1 + 1;
    end
  end

  task automatic pulse_start();
    i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_Byte  = b;
    i_Valid = 1'b1;
    while (!rdy0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy0) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout: ready=%0b required 1", rdy0);
    end
    @(negedge clk);
    i_Valid = 1'b0;
  endtask

  task automatic send_seq(input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      send_byte(seq[k]);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done0 !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: done=%0b required 1", done0);
    end
  endtask

  task automatic load_two_words_seq();
    seq[0] = 8'h02; seq[1] = 8'h00;
    seq[2] = 8'h13; seq[3] = 8'h05; seq[4]  = 8'hA0; seq[5]  = 8'h00;
    seq[6] = 8'h93; seq[7] = 8'h05; seq[8]  = 8'hB0; seq[9]  = 8'h00;
  endtask

  task automatic check_two_writes(input string tag, input int base0, input int base1);
    checks++;
    if (wr_n0 - base0 !== 2) begin
      errors++;
      $display("FAIL %s_wr_count: got %0d required 2", tag, wr_n0 - base0);
    end else begin
      checks++;
      if (wr_data0[base0] !== 32'h00A00513 || wr_addr0[base0] !== 32'h0) begin
        errors++;
        $display("FAIL %s_word0: got %h@%h required 00a00513@00000000", tag, wr_data0[base0], wr_addr0[base0]);
      end
      checks++;
      if (wr_data0[base0+1] !== 32'h00B00593 || wr_addr0[base0+1] !== 32'h4) begin
        errors++;
        $display("FAIL %s_word1: got %h@%h required 00b00593@00000004", tag, wr_data0[base0+1], wr_addr0[base0+1]);
      end
    end
    checks++;
    if (wr_n1 - base1 !== 2 || wr_addr1[base1] !== 32'h100 || wr_addr1[base1+1] !== 32'h104) begin
      errors++;
      $display("FAIL %s_base100_addrs: got n=%0d %h %h required n=2 00000100 00000104",
               tag, wr_n1 - base1, wr_addr1[base1], wr_addr1[base1+1]);
    end
    checks++;
    if (cnt0 !== 16'd2 || done0 !== 1'b1 || hold0 !== 1'b0 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL %s_final: got cnt=%0d done=%0b hold=%0b err=%0b required 2 1 0 0",
               tag, cnt0, done0, hold0, err0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b0 || wen0 !== 1'b0 || hold0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0 ||
        addr0 !== 32'h0 || data0 !== 32'h0 || cnt0 !== 16'h0 || addr1 !== 32'h100) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b wen=%0b hold=%0b done=%0b err=%0b addr=%h data=%h cnt=%0d addr1=%h required all zero, addr1=00000100",
               rdy0, wen0, hold0, done0, err0, addr0, data0, cnt0, addr1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    int b0 = wr_n0;
    int b1 = wr_n1;
    load_two_words_seq();
    pulse_start();
    checks++;
    if (hold0 !== 1'b1 || rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL start_hold: got hold=%0b ready=%0b required 1 1", hold0, rdy0);
    end
    send_seq(6, 1'b0);
    // 4th data byte just accepted: the write is in this cycle
    checks++;
    if (wen0 !== 1'b1 || rdy0 !== 1'b0 || data0 !== 32'h00A00513) begin
      errors++;
      $display("FAIL write_latency: got wen=%0b ready=%0b data=%h required 1 0 00a00513", wen0, rdy0, data0);
    end
    for (int k = 6; k < 10; k++) send_byte(seq[k]);
    wait_done();
    check_two_writes("basic", b0, b1);
  endtask

  task automatic test_valid_toggle();
    int b0 = wr_n0;
    int b1 = wr_n1;
    load_two_words_seq();
    pulse_start();
    send_seq(10, 1'b1);
    wait_done();
    check_two_writes("toggle", b0, b1);
  endtask

  task automatic test_zero_length();
    int b0 = wr_n0;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    checks++;
    if (done0 !== 1'b1 || err0 !== 1'b0 || hold0 !== 1'b0 || cnt0 !== 16'd0) begin
      errors++;
      $display("FAIL zero_len: got done=%0b err=%0b hold=%0b cnt=%0d required 1 0 0 0", done0, err0, hold0, cnt0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_n0 !== b0) begin
      errors++;
      $display("FAIL zero_len_writes: got %0d required 0", wr_n0 - b0);
    end
  endtask

  task automatic test_overlength();
    int b0 = wr_n0;
    pulse_start();
    send_byte(8'h41);
    send_byte(8'h00);
    checks++;
    if (err0 !== 1'b1 || done0 !== 1'b1 || hold0 !== 1'b0 || rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL overlen: got err=%0b done=%0b hold=%0b ready=%0b required 1 1 0 0", err0, done0, hold0, rdy0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_n0 !== b0 || err0 !== 1'b1) begin
      errors++;
      $display("FAIL overlen_sticky: got writes=%0d err=%0b required 0 1", wr_n0 - b0, err0);
    end
    pulse_start();
    checks++;
    if (err0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL overlen_clear: got err=%0b done=%0b required 0 0", err0, done0);
    end
    send_byte(8'h00);
    send_byte(8'h00);
  endtask

  task automatic test_reset_midload();
    int b0 = wr_n0;
    int b1 = wr_n1;
    load_two_words_seq();
    pulse_start();
    send_seq(8, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (rdy0 !== 1'b0 || wen0 !== 1'b0 || hold0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0 ||
        addr0 !== 32'h0 || data0 !== 32'h0 || cnt0 !== 16'h0 || addr1 !== 32'h100) begin
      errors++;
      $display("FAIL midload_reset: rdy=%0b wen=%0b hold=%0b done=%0b err=%0b addr=%h data=%h cnt=%0d addr1=%h required all zero, addr1=00000100",
               rdy0, wen0, hold0, done0, err0, addr0, data0, cnt0, addr1);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_n0 - b0 !== 1 || wr_data0[b0] !== 32'h00A00513) begin
      errors++;
      $display("FAIL midload_writes: got n=%0d data=%h required n=1 00a00513", wr_n0 - b0, wr_data0[b0]);
    end
    b0 = wr_n0;
    b1 = wr_n1;
    pulse_start();
    send_seq(10, 1'b0);
    wait_done();
    check_two_writes("after_reset", b0, b1);
  endtask

  task automatic test_back_to_back();
    int b0 = wr_n0;
    int b1 = wr_n1;
    load_two_words_seq();
    pulse_start();
    send_seq(4, 1'b0);
    pulse_start();
    checks++;
    if (hold0 !== 1'b1 || done0 !== 1'b0 || rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL start_in_data: got hold=%0b done=%0b ready=%0b required 1 0 1", hold0, done0, rdy0);
    end
    for (int k = 4; k < 10; k++) send_byte(seq[k]);
    wait_done();
    check_two_writes("start_ignored", b0, b1);
    b0 = wr_n0;
    pulse_start();
    checks++;
    if (done0 !== 1'b0 || hold0 !== 1'b1 || cnt0 !== 16'd0 || addr0 !== 32'h0) begin
      errors++;
      $display("FAIL reload_start: got done=%0b hold=%0b cnt=%0d addr=%h required 0 1 0 00000000",
               done0, hold0, cnt0, addr0);
    end
    seq[0] = 8'h01; seq[1] = 8'h00;
    seq[2] = 8'h78; seq[3] = 8'h56; seq[4] = 8'h34; seq[5] = 8'h12;
    send_seq(6, 1'b0);
    wait_done();
    checks++;
    if (wr_n0 - b0 !== 1 || wr_data0[b0] !== 32'h12345678 || wr_addr0[b0] !== 32'h0 || cnt0 !== 16'd1) begin
      errors++;
      $display("FAIL reload_write: got n=%0d %h@%h cnt=%0d required n=1 12345678@00000000 cnt=1",
               wr_n0 - b0, wr_data0[b0], wr_addr0[b0], cnt0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_load();
    test_valid_toggle();
    test_zero_length();
    test_overlength();
    test_reset_midload();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
